// File: rtl/audio_mixer.sv
// audio_mixer: time-multiplexed stereo mixer.
// Each pass snapshots NUM_CH signed samples with their gains and pan masks,
// then accumulates one channel per cycle into wide left/right sums. The
// wide sums are saturated to IN_W bits at the end of the pass.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for sample_ce; snapshot inputs and clear sums on start
// S_ACC  | add scaled channel r_idx to the sides selected by its pan mask
// S_OUT  | saturate sums, apply mute, publish outputs, pulse out_valid
module audio_mixer #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int GAIN_W = 4
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     sample_ce,
    input  logic                     mute,
    input  logic [NUM_CH*IN_W-1:0]   ch_in,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH*2-1:0]      ch_pan,
    output logic [IN_W-1:0]          audio_l,
    output logic [IN_W-1:0]          audio_r,
    output logic                     out_valid,
    output logic                     clip_l,
    output logic                     clip_r,
    output logic                     busy,
    output logic                     overrun
);

    // Product width holds sample * {0,gain}; the extra $clog2(NUM_CH) bits
    // guarantee the running sum of all channels cannot wrap.
    localparam int P_W   = IN_W + GAIN_W + 1;
    localparam int ACC_W = P_W + $clog2(NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t                    r_state;
    logic [NUM_CH*IN_W-1:0]    r_ch;
    logic [NUM_CH*GAIN_W-1:0]  r_gain;
    logic [NUM_CH*2-1:0]       r_pan;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc_l;
    logic signed [ACC_W-1:0]   r_acc_r;
    logic [IN_W-1:0]           r_audio_l;
    logic [IN_W-1:0]           r_audio_r;
    logic                      r_out_valid;
    logic                      r_clip_l;
    logic                      r_clip_r;
    logic                      r_busy;
    logic                      r_overrun;

    logic signed [IN_W-1:0]    w_sample;
    logic [GAIN_W-1:0]         w_gain;
    logic [1:0]                w_pan;
    logic signed [P_W-1:0]     w_samp_x;
    logic signed [P_W-1:0]     w_gain_x;
    logic signed [P_W-1:0]     w_prod;
    logic signed [P_W-1:0]     w_s;
    logic signed [ACC_W-1:0]   w_s_x;
    logic [IN_W:0]             w_sat_l;
    logic [IN_W:0]             w_sat_r;
    logic                      w_last;

    // Saturate a wide sum to IN_W bits; MSB of the result flags clipping.
    // The value fits exactly when all bits from IN_W-1 upward match the sign.
    function automatic logic [IN_W:0] sat(input logic [ACC_W-1:0] a);
        logic [ACC_W-IN_W:0] hi;
        hi = a[ACC_W-1:IN_W-1];
        if (hi == {(ACC_W-IN_W+1){a[ACC_W-1]}})
            sat = {1'b0, a[IN_W-1:0]};
        else if (a[ACC_W-1])
            sat = {1'b1, 1'b1, {(IN_W-1){1'b0}}};
        else
            sat = {1'b1, 1'b0, {(IN_W-1){1'b1}}};
    endfunction

    assign w_sample = r_ch[int'(r_idx)*IN_W +: IN_W];
    assign w_gain   = r_gain[int'(r_idx)*GAIN_W +: GAIN_W];
    assign w_pan    = r_pan[int'(r_idx)*2 +: 2];

    // Gain is unsigned, so it is zero-extended before the signed multiply;
    // the true product always fits in P_W bits.
    assign w_samp_x = P_W'(w_sample);
    assign w_gain_x = P_W'({1'b0, w_gain});
    assign w_prod   = w_samp_x * w_gain_x;
    assign w_s      = w_prod >>> 3;
    assign w_s_x    = ACC_W'(w_s);

    assign w_sat_l  = sat(r_acc_l);
    assign w_sat_r  = sat(r_acc_r);
    assign w_last   = (r_idx == IDX_W'(NUM_CH - 1));

    // Pass sequencer: snapshot, per-channel accumulate, saturate and publish.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_gain      <= '0;
            r_pan       <= '0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_audio_l   <= '0;
            r_audio_r   <= '0;
            r_out_valid <= 1'b0;
            r_clip_l    <= 1'b0;
            r_clip_r    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_clip_l    <= 1'b0;
            r_clip_r    <= 1'b0;
            r_overrun   <= sample_ce && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sample_ce) begin
                        r_ch    <= ch_in;
                        r_gain  <= ch_gain;
                        r_pan   <= ch_pan;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_pan[0])
                        r_acc_l <= r_acc_l + w_s_x;
                    if (w_pan[1])
                        r_acc_r <= r_acc_r + w_s_x;
                    r_idx <= r_idx + 1'b1;
                    if (w_last)
                        r_state <= S_OUT;
                end
                S_OUT: begin
                    if (mute) begin
                        r_audio_l <= '0;
                        r_audio_r <= '0;
                    end else begin
                        r_audio_l <= w_sat_l[IN_W-1:0];
                        r_audio_r <= w_sat_r[IN_W-1:0];
                        r_clip_l  <= w_sat_l[IN_W];
                        r_clip_r  <= w_sat_r[IN_W];
                    end
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign audio_l   = r_audio_l;
    assign audio_r   = r_audio_r;
    assign out_valid = r_out_valid;
    assign clip_l    = r_clip_l;
    assign clip_r    = r_clip_r;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Parametrised, time-multiplexed stereo audio mixer that replaces the fixed single-LUT-plus-adder summing at the top level. Each mix pass snapshots NUM_CH signed channel samples: TIA LUT output, POKEY, YM left/right and future expansion sources. It scales each sample by a per-channel gain, routes it to left and/or right per a pan mask, and sums one channel per cycle. Each output is saturated to 16 bits. It runs on clk_sys and starts a pass on each sample_ce strobe.

## Interface
Parameters:
- NUM_CH, 4: number of input channels, 1..16.
- IN_W, 16: signed sample width per channel; it is also the output width.
- GAIN_W, 4: unsigned gain width. Gain value 8 is unity (gain/8). With GAIN_W=4 the range is 0..1.875.

Ports:
- clk_sys  in  1  system clock. Reset rst, synchronous, active-high; clock clk_sys.
- rst  in  1  synchronous active-high reset.
- sample_ce  in  1  single-cycle request to start a mix pass.
- mute  in  1  forces zero outputs for the pass in which it is sampled at the output edge.
- ch_in  in  NUM_CH*IN_W  packed signed samples; channel k is at bits [k*IN_W +: IN_W].
- ch_gain  in  NUM_CH*GAIN_W  packed unsigned gains; channel k is at [k*GAIN_W +: GAIN_W].
- ch_pan  in  NUM_CH*2  per-channel pan: bit0 = route to left, bit1 = route to right.
- audio_l  out  IN_W  signed left mix, held between passes.
- audio_r  out  IN_W  signed right mix, held between passes.
- out_valid  out  1  one-cycle pulse when audio_l/audio_r update.
- clip_l, clip_r  out  1  asserted together with out_valid if that side saturated in this pass; 0 otherwise.
- busy  out  1  high while a pass is in progress.
- overrun  out  1  one-cycle pulse when sample_ce arrives while busy.

## Operation
- State machine with three states:
  - IDLE: busy=0. sample_ce=1 snapshots ch_in, ch_gain and ch_pan into internal registers, clears acc_l and acc_r, sets idx=0, then goes to ACC.
  - ACC: busy=1. Each cycle processes channel idx:
    - p = signed(sample) * {0, gain}, width IN_W+GAIN_W+1.
    - s = p >>> 3 (arithmetic, floor).
    - acc_l += s if pan[0]; acc_r += s if pan[1].
    - idx increments; after idx == NUM_CH-1 go to OUT.
  - OUT: busy=1.
    - Each accumulator is clamped to [-2^(IN_W-1), 2^(IN_W-1)-1] and registered to audio_l/audio_r.
    - clip_x = 1 if clamping changed the value.
    - If mute=1, the outputs are 0 and clip_l = clip_r = 0.
    - out_valid pulses; next state is IDLE.
- Accumulator width: ACC_W = IN_W+GAIN_W+1+$clog2(NUM_CH). It must never wrap internally; only the final clamp limits range.
- Inputs change freely after the snapshot edge; the pass uses the snapshot only.
- sample_ce while in ACC or OUT is ignored (no queueing) and raises overrun for one cycle.
- gain 0 or pan 00 means the channel contributes nothing. A channel with pan 11 adds the identical s to both sides.

## Timing
- Reset values: audio_l=0, audio_r=0, out_valid=0, clip_l=0, clip_r=0, busy=0, overrun=0, state=IDLE, accumulators 0.
- Edge numbering for one pass:
  - E0: the edge where sample_ce is sampled high in IDLE. busy=1 from after E0.
  - E(1+k): the edge where channel k accumulates.
  - E(NUM_CH+1): the OUT edge. Outputs update, out_valid=1 and busy=0 for the following cycle.
- Latency from sample_ce to out_valid is NUM_CH+1 edges. The earliest next accepted sample_ce is at E(NUM_CH+2), so the minimum pass period is NUM_CH+2 cycles.
- sample_ce at E(NUM_CH+1) (state OUT) is ignored and flagged as overrun.
- overrun, out_valid and clip_x are registered and last exactly one cycle.
- Reset mid-pass has priority: the pass is aborted, there is no out_valid, and outputs return to 0 at the reset edge.
- mute is sampled only at the OUT edge.

## Test plan
- Reset: hold rst 3 cycles. All outputs 0, busy=0. Then sample_ce with all channels 0 -> out_valid with L=R=0.
- Unity mix, NUM_CH=4: ch_in = {1000, 2000, -500, 0}, gains all 8, pans all 11, sample_ce at E0 -> out_valid after E5, audio_l = audio_r = 2500, clip_l = clip_r = 0, busy high for cycles E0..E4.
- Saturation and rounding:
  - All channels 30000, gain 15, pan 11 -> both sides 32767 with clip_l = clip_r = 1.
  - All channels -30000, same gains -> -32768 with clips set.
  - One channel -1 at gain 1 -> -1 (floor).
- Pan, gain, mute:
  - ch0 = 1000 with pan 01 and ch1 = 2000 with pan 10, gain 4 -> L=500, R=1000.
  - Repeat with mute=1 at the OUT edge -> L=R=0, clips 0, out_valid still pulses.
- Overrun: sample_ce at E0 and at E2 -> overrun pulse in the cycle after E2. Only one out_valid, after E5, with the E0 snapshot values even though ch_in changed at E1.
- Reset mid-pass: start a pass with a nonzero mix, assert rst at E2 -> no out_valid, outputs 0. A new sample_ce after reset completes normally.
